alu_result_stage: RTL and testbench

Registered EX-to-MEM boundary placed directly downstream of the 32-bit MIPS ALU. It captures the ALU result, flags and destination register once per instruction through a valid/ready handshake. A 2-entry skid buffer lets in_ready be a pure register output. It applies ADD/SUB overflow-trap suppression of the register write and counts delivered traps.

---
 rtl/alu_result_stage.sv | 117 +++++++++++
 tb/tb_alu_result_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// EX-to-MEM result register behind the ALU: 2-entry skid buffer with a registered in_ready,
// overflow-trap write suppression at capture, and a saturating count of delivered traps.
module alu_result_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_r,
   input  logic              in_zero,
   input  logic              in_carry,
   input  logic              in_negative,
   input  logic              in_overflow,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_wen,
   input  logic              in_trap_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_r,
   output logic [3:0]        out_flags,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_wen,
   output logic              out_trap,
   output logic [CNT_W-1:0]  trap_count
);

   typedef struct packed {
      logic [DATA_W-1:0] r;
      logic [3:0]        flags;
      logic [REG_W-1:0]  rd;
      logic              wen;
      logic              trap;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t           state_q, state_d;
   entry_t           main_q, main_d, skid_q, skid_d, cap;
   logic             in_ready_q, accept, deliver, cap_trap;
   logic [CNT_W-1:0] cnt_q;

   assign accept    = in_valid & in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign deliver   = out_valid & out_ready;

   // Trap and write-enable are resolved once, when the entry is captured
   assign cap_trap = in_trap_en & in_overflow;
   always_comb begin
      cap.r     = in_r;
      cap.flags = {in_zero, in_carry, in_negative, in_overflow};
      cap.rd    = in_rd;
      cap.trap  = cap_trap;
      cap.wen   = in_wen & ~cap_trap & (in_rd != '0);
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: if (accept) begin
               state_d = ONE;
               main_d  = cap;
            end
            ONE: begin
               if (accept && !deliver) begin
                  state_d = TWO;
                  skid_d  = cap;
               end else if (accept && deliver) begin
                  main_d = cap;
               end else if (deliver) begin
                  state_d = EMPTY;
               end
            end
            TWO: if (deliver) begin
               state_d = ONE;
               main_d  = skid_q;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != TWO);
         // A delivery during flush is discarded, so it is not counted
         if (deliver && main_q.trap && !flush && (cnt_q != '1))
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign in_ready   = in_ready_q;
   assign out_r      = main_q.r;
   assign out_flags  = main_q.flags;
   assign out_rd     = main_q.rd;
   assign out_wen    = main_q.wen;
   assign out_trap   = main_q.trap;
   assign trap_count = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed checks of alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;

   localparam int DW = 32, RW = 5, CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid;
   logic [DW-1:0] in_r = '0, out_r;
   logic in_zero = 0, in_carry = 0, in_negative = 0, in_overflow = 0;
   logic [RW-1:0] in_rd = '0, out_rd;
   logic in_wen = 0, in_trap_en = 0;
   logic [3:0] out_flags;
   logic out_wen, out_trap;
   logic [CW-1:0] trap_count;

   alu_result_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_zero(in_zero), .in_carry(in_carry),
      .in_negative(in_negative), .in_overflow(in_overflow),
      .in_rd(in_rd), .in_wen(in_wen), .in_trap_en(in_trap_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_flags(out_flags), .out_rd(out_rd),
      .out_wen(out_wen), .out_trap(out_trap), .trap_count(trap_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] r;
      logic z, c, n, o;
      logic [RW-1:0] rd;
      logic wen, te;
   } stim_t;

   typedef struct {
      logic [DW-1:0] r;
      logic [3:0] f;
      logic [RW-1:0] rd;
      logic wen, trap;
   } exp_t;

   exp_t q[$];
   int   m_cnt = 0;
   bit   m_rdy = 1;
   int   n_cmp = 0, n_bad = 0;

   function automatic stim_t mk(logic [DW-1:0] r, logic o, logic te, logic wen, logic [RW-1:0] rd);
      stim_t s;
      s.r = r; s.z = (r == 0); s.c = 1'b0; s.n = r[DW-1]; s.o = o;
      s.rd = rd; s.wen = wen; s.te = te;
      return s;
   endfunction

   // Drive one cycle starting from a negedge; model advances on the edge; returns at next negedge
   task automatic step(input stim_t s, input logic v, input logic ordy, input logic fl);
      exp_t e;
      bit acc, del;
      in_valid = v; in_r = s.r; in_zero = s.z; in_carry = s.c; in_negative = s.n;
      in_overflow = s.o; in_rd = s.rd; in_wen = s.wen; in_trap_en = s.te;
      out_ready = ordy; flush = fl;
      acc = v && m_rdy;
      del = (q.size() > 0) && ordy;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (del) begin
            e = q.pop_front();
            if (e.trap && m_cnt < CMAX) m_cnt++;
         end
         if (acc) begin
            e.r = s.r; e.f = {s.z, s.c, s.n, s.o}; e.rd = s.rd;
            e.trap = s.te && s.o;
            e.wen = s.wen && !e.trap && (s.rd != 0);
            q.push_back(e);
         end
      end
      m_rdy = (q.size() < 2);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic idle(input logic ordy);
      step(mk('0, 0, 0, 0, '0), 1'b0, ordy, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q.delete(); m_cnt = 0; m_rdy = 1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({out_valid, in_ready, out_r, out_flags, out_rd, out_wen, out_trap, trap_count} !== {1'b0, 1'b1, {(DW+4+RW+2+CW){1'b0}}}) begin
         n_bad++;
         $display("FAIL reset_state: valid=%b ready=%b r=%h cnt=%0d, required 0/1/0/0", out_valid, in_ready, out_r, trap_count);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      step(mk(32'h5, 0, 0, 1, 5'd3), 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({out_valid, out_r, out_rd, out_wen} !== {1'b1, 32'h5, 5'd3, 1'b1}) begin
         n_bad++;
         $display("FAIL single_capture: valid=%b r=%h rd=%0d wen=%b, required 1/5/3/1", out_valid, out_r, out_rd, out_wen);
      end
      idle(1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL single_drain: valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      step(mk(32'h11, 0, 0, 1, 5'd1), 1'b1, 1'b0, 1'b0);
      step(mk(32'h22, 0, 0, 1, 5'd2), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({in_ready, out_valid, out_r} !== {1'b0, 1'b1, 32'h11}) begin
         n_bad++;
         $display("FAIL backpressure_full: ready=%b valid=%b r=%h, required 0/1/11", in_ready, out_valid, out_r);
      end
      idle(1'b0);
      n_cmp++;
      if ({in_ready, out_r} !== {1'b0, 32'h11}) begin
         n_bad++;
         $display("FAIL backpressure_hold: ready=%b r=%h, required 0/11", in_ready, out_r);
      end
      idle(1'b1);
      n_cmp++;
      if ({in_ready, out_valid, out_r, out_rd} !== {1'b1, 1'b1, 32'h22, 5'd2}) begin
         n_bad++;
         $display("FAIL backpressure_second: ready=%b valid=%b r=%h rd=%0d, required 1/1/22/2", in_ready, out_valid, out_r, out_rd);
      end
      idle(1'b1);
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL backpressure_empty: ready=%b valid=%b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_trap();
      step(mk(32'h8000_0000, 1, 1, 1, 5'd8), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({out_trap, out_wen, out_flags, trap_count} !== {1'b1, 1'b0, 4'b0011, 2'd0}) begin
         n_bad++;
         $display("FAIL trap_capture: trap=%b wen=%b flags=%b cnt=%0d, required 1/0/0011/0", out_trap, out_wen, out_flags, trap_count);
      end
      idle(1'b1);
      n_cmp++;
      if (trap_count !== 2'd1) begin
         n_bad++;
         $display("FAIL trap_count_inc: cnt=%0d, required 1", trap_count);
      end
      step(mk(32'h8000_0000, 1, 0, 1, 5'd8), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({out_trap, out_wen} !== 2'b01) begin
         n_bad++;
         $display("FAIL notrap_capture: trap=%b wen=%b, required 0/1", out_trap, out_wen);
      end
      idle(1'b1);
      n_cmp++;
      if (trap_count !== 2'd1) begin
         n_bad++;
         $display("FAIL notrap_count: cnt=%0d, required 1", trap_count);
      end
   endtask

   task automatic test_zero_rd();
      step(mk(32'h1234, 0, 0, 1, 5'd0), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({out_valid, out_wen} !== 2'b10) begin
         n_bad++;
         $display("FAIL zero_rd_wen: valid=%b wen=%b, required 1/0", out_valid, out_wen);
      end
      idle(1'b1);
   endtask

   task automatic test_flush();
      step(mk(32'hA, 1, 1, 1, 5'd4), 1'b1, 1'b0, 1'b0);
      step(mk(32'hB, 0, 0, 1, 5'd5), 1'b1, 1'b0, 1'b0);
      step(mk(32'hC, 0, 0, 1, 5'd6), 1'b1, 1'b1, 1'b1);
      n_cmp++;
      if ({out_valid, in_ready, trap_count} !== {1'b0, 1'b1, 2'd1}) begin
         n_bad++;
         $display("FAIL flush_two: valid=%b ready=%b cnt=%0d, required 0/1/1", out_valid, in_ready, trap_count);
      end
      idle(1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_discard: valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_saturation();
      logic [CW-1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(mk(32'h7FFF_FFF0 + i, 1, 1, 1, 5'd9), 1'b1, 1'b0, 1'b0);
         idle(1'b1);
         n_cmp++;
         if (trap_count !== exp_seq[i]) begin
            n_bad++;
            $display("FAIL saturation[%0d]: cnt=%0d, required %0d", i, trap_count, exp_seq[i]);
         end
      end
      step(mk(32'hDEAD_BEEF, 1, 1, 1, 5'd7), 1'b1, 1'b0, 1'b0);
      step(mk(32'h1, 0, 0, 1, 5'd2), 1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, in_ready, out_r, out_flags, out_rd, out_wen, out_trap, trap_count} !== {1'b0, 1'b1, {(DW+4+RW+2+CW){1'b0}}}) begin
         n_bad++;
         $display("FAIL async_reset: valid=%b ready=%b r=%h trap=%b cnt=%0d, required all 0, ready 1", out_valid, in_ready, out_r, out_trap, trap_count);
      end
      q.delete(); m_cnt = 0; m_rdy = 1;
      @(negedge clk);
      rst = 1'b0;
      idle(1'b1);
      n_cmp++;
      if ({out_valid, out_r} !== {1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL skid_cleared: valid=%b r=%h, required 0/0", out_valid, out_r);
      end
   endtask

   task automatic test_random();
      stim_t s;
      logic [DW+4+RW+1:0] got, want;
      for (int i = 0; i < 400; i++) begin
         s = mk($urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                RW'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)));
         s.c = $urandom_range(0, 1);
         step(s, $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
         n_cmp++;
         if ({out_valid, in_ready, trap_count} !== {q.size() > 0, m_rdy, CW'(m_cnt)}) begin
            n_bad++;
            $display("FAIL rand_ctrl[%0d]: valid=%b ready=%b cnt=%0d, required %b/%b/%0d", i, out_valid, in_ready, trap_count, q.size() > 0, m_rdy, m_cnt);
         end
         if (q.size() > 0) begin
            got  = {out_r, out_flags, out_rd, out_wen, out_trap};
            want = {q[0].r, q[0].f, q[0].rd, q[0].wen, q[0].trap};
            n_cmp++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL rand_data[%0d]: got %h, required %h", i, got, want);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_trap();
      test_zero_rd();
      test_flush();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
